// File: rtl/bolme_birimi.sv
// bolme_birimi: 32-bit integer divide/remainder unit for the yurut stage.
// Restoring radix-2 divider on operand magnitudes, one quotient bit per clock.
// Divide-by-zero and signed overflow are answered in the accept cycle
// without entering the iteration loop.
module bolme_birimi (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        basla_i,
  input  logic [1:0]  islem_i,
  input  logic [31:0] bolunen_i,
  input  logic [31:0] bolen_i,
  output logic [31:0] sonuc_o,
  output logic        bolme_bitti_o
);

  localparam logic [1:0] BOSTA   = 2'd0;
  localparam logic [1:0] HESAPLA = 2'd1;
  localparam logic [1:0] BITTI   = 2'd2;

  logic [1:0]  durum_reg, durum_next;
  logic [4:0]  sayac_reg;
  logic [31:0] bolum_reg;    // dividend magnitude shifts out, quotient shifts in
  logic [31:0] bolen_reg;
  logic [31:0] kalan_reg;    // always below the divisor, so 32 bits hold it
  logic        isaret_reg;
  logic [1:0]  islem_reg;
  logic [31:0] sonuc_reg;

  // Operand decode for the accept cycle
  logic        isaretli;
  logic        bolunen_neg, bolen_neg;
  logic [31:0] bolunen_mutlak, bolen_mutlak;
  logic        sifira_bolme, tasma, ozel_durum;
  logic [31:0] ozel_sonuc;
  logic        isaret_yeni;
  logic        kabul, ozel_kabul;

  // Iteration datapath
  logic [32:0] kalan_kaydir;  // 33-bit trial value
  logic [32:0] fark;
  logic        bit_q;
  logic [31:0] kalan_yeni;
  logic [31:0] bolum_yeni;
  logic [31:0] ham_sonuc;
  logic [31:0] son_sonuc;

  // Decode operands, detect the zero-latency special cases
  always_comb begin
    isaretli       = ~islem_i[0];
    bolunen_neg    = isaretli & bolunen_i[31];
    bolen_neg      = isaretli & bolen_i[31];
    bolunen_mutlak = bolunen_neg ? (~bolunen_i + 32'd1) : bolunen_i;
    bolen_mutlak   = bolen_neg ? (~bolen_i + 32'd1) : bolen_i;
    sifira_bolme   = (bolen_i == 32'd0);
    tasma          = isaretli && (bolunen_i == 32'h8000_0000) && (bolen_i == 32'hFFFF_FFFF);
    ozel_durum     = sifira_bolme | tasma;
    if (sifira_bolme)
      ozel_sonuc = islem_i[1] ? bolunen_i : 32'hFFFF_FFFF;
    else
      ozel_sonuc = islem_i[1] ? 32'd0 : 32'h8000_0000;
    // remainder follows the dividend sign, quotient follows the sign difference
    isaret_yeni    = islem_i[1] ? bolunen_neg : (bolunen_neg ^ bolen_neg);
    kabul          = (durum_reg == BOSTA) && basla_i && !ozel_durum;
    ozel_kabul     = (durum_reg == BOSTA) && basla_i && ozel_durum;
  end

  // One restoring step: shift in next dividend bit, keep the difference if non-negative
  always_comb begin
    kalan_kaydir = {kalan_reg, bolum_reg[31]};
    fark         = kalan_kaydir - {1'b0, bolen_reg};
    bit_q        = ~fark[32];
    kalan_yeni   = bit_q ? fark[31:0] : kalan_kaydir[31:0];
    bolum_yeni   = {bolum_reg[30:0], bit_q};
    ham_sonuc    = islem_reg[1] ? kalan_yeni : bolum_yeni;
    son_sonuc    = isaret_reg ? (~ham_sonuc + 32'd1) : ham_sonuc;
  end

  // Next-state selection
  always_comb begin
    durum_next = durum_reg;
    case (durum_reg)
      BOSTA:   durum_next = kabul ? HESAPLA : BOSTA;
      HESAPLA: durum_next = (sayac_reg == 5'd31) ? BITTI : HESAPLA;
      BITTI:   durum_next = BOSTA;
      default: durum_next = BOSTA;
    endcase
  end

  // State, operand latches, iteration registers and result register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_reg  <= BOSTA;
      sayac_reg  <= 5'd0;
      bolum_reg  <= 32'd0;
      bolen_reg  <= 32'd0;
      kalan_reg  <= 32'd0;
      isaret_reg <= 1'b0;
      islem_reg  <= 2'd0;
      sonuc_reg  <= 32'd0;
    end else begin
      durum_reg <= durum_next;
      case (durum_reg)
        BOSTA: begin
          if (kabul) begin
            bolum_reg  <= bolunen_mutlak;
            bolen_reg  <= bolen_mutlak;
            kalan_reg  <= 32'd0;
            sayac_reg  <= 5'd0;
            isaret_reg <= isaret_yeni;
            islem_reg  <= islem_i;
          end
          if (ozel_kabul)
            sonuc_reg <= ozel_sonuc;
        end
        HESAPLA: begin
          kalan_reg <= kalan_yeni;
          bolum_reg <= bolum_yeni;
          sayac_reg <= sayac_reg + 5'd1;
          // last step: publish signed result so it is valid in BITTI
          if (sayac_reg == 5'd31)
            sonuc_reg <= son_sonuc;
        end
        default: ;
      endcase
    end
  end

  // Outputs: special cases bypass the register in the accept cycle
  always_comb begin
    sonuc_o       = sonuc_reg;
    bolme_bitti_o = 1'b1;
    case (durum_reg)
      BOSTA: begin
        if (ozel_kabul)
          sonuc_o = ozel_sonuc;
        bolme_bitti_o = !kabul;
      end
      HESAPLA: bolme_bitti_o = 1'b0;
      default: bolme_bitti_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bolme_birimi.sv
// Testbench for bolme_birimi: directed divide/remainder vectors with literal
// expectations, plus a cycle-level reference model compared every clock.
module tb_bolme_birimi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        basla_i;
  logic [1:0]  islem_i;
  logic [31:0] bolunen_i;
  logic [31:0] bolen_i;
  logic [31:0] sonuc_o;
  logic        bolme_bitti_o;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  bolme_birimi dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .basla_i       (basla_i),
    .islem_i       (islem_i),
    .bolunen_i     (bolunen_i),
    .bolen_i       (bolen_i),
    .sonuc_o       (sonuc_o),
    .bolme_bitti_o (bolme_bitti_o)
  );

  always #5 clk_i = ~clk_i;

  int dogrulama = 0;
  int hata = 0;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    dogrulama++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: actual=%h required=%h", ad, gercek, beklenen);
    end
  endtask

  // Architectural result of one instruction (RISC-V M semantics)
  function automatic bit ozel_mi(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] beklenen_sonuc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      DIV:     return 32'($signed(a) / $signed(b));
      DIVU:    return a / b;
      REM:     return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Reference model: idle, or n cycles since acceptance (1..32 busy, 33 = result shown)
  int          m_adim = 0;
  bit          m_gecerli = 0;
  logic [31:0] m_son;
  logic [31:0] m_bekleyen;
  logic [31:0] e_sonuc;
  logic        e_bitti;

  // Compare DUT outputs with the model each cycle, then advance the model over the coming edge
  always @(negedge clk_i) begin
    if (m_gecerli) begin
      if (m_adim == 0) begin
        if (basla_i && ozel_mi(islem_i, bolunen_i, bolen_i)) begin
          e_bitti = 1'b1;
          e_sonuc = beklenen_sonuc(islem_i, bolunen_i, bolen_i);
        end else begin
          e_bitti = !basla_i;
          e_sonuc = m_son;
        end
      end else if (m_adim <= 32) begin
        e_bitti = 1'b0;
        e_sonuc = m_son;
      end else begin
        e_bitti = 1'b1;
        e_sonuc = m_bekleyen;
      end
      kontrol("cycle bolme_bitti_o", {31'd0, bolme_bitti_o}, {31'd0, e_bitti});
      kontrol("cycle sonuc_o", sonuc_o, e_sonuc);
    end
    if (rst_i) begin
      m_adim    = 0;
      m_son     = 32'd0;
      m_gecerli = 1;
    end else if (m_gecerli) begin
      if (m_adim == 0) begin
        if (basla_i) begin
          if (ozel_mi(islem_i, bolunen_i, bolen_i))
            m_son = beklenen_sonuc(islem_i, bolunen_i, bolen_i);
          else begin
            m_bekleyen = beklenen_sonuc(islem_i, bolunen_i, bolen_i);
            m_adim = 1;
          end
        end
      end else if (m_adim <= 32) begin
        m_adim++;
      end else begin
        m_adim = 0;
        m_son  = m_bekleyen;
      end
    end
  end

  // Issue one instruction, count busy cycles, check the result when done
  task automatic islem_yap(input string ad, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_sonuc,
                           input int exp_gecikme, input bit karistir);
    int gecikme = 0;
    bit bitti = 0;
    @(posedge clk_i); #1;
    basla_i = 1'b1; islem_i = op; bolunen_i = a; bolen_i = b;
    for (int i = 0; i < 100 && !bitti; i++) begin
      @(negedge clk_i);
      if (bolme_bitti_o === 1'b1) bitti = 1;
      else begin
        gecikme++;
        if (karistir && gecikme == 5) begin
          #2;
          islem_i = ~op; bolunen_i = 32'h8000_0000; bolen_i = 32'd0;
        end
      end
    end
    kontrol({ad, " done"}, {31'd0, bitti}, 32'd1);
    kontrol({ad, " latency"}, 32'(gecikme), 32'(exp_gecikme));
    kontrol({ad, " result"}, sonuc_o, exp_sonuc);
    $display("op=%0d a=%h b=%h -> sonuc=%h latency=%0d (%s)", op, a, b, sonuc_o, gecikme, ad);
  endtask

  task automatic bosta();
    @(posedge clk_i); #1;
    basla_i = 1'b0;
  endtask

  initial begin
    bit temiz;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    rst_i = 1'b1; basla_i = 1'b0; islem_i = 2'd0; bolunen_i = 32'd0; bolen_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    kontrol("reset sonuc_o", sonuc_o, 32'd0);
    kontrol("reset bolme_bitti_o", {31'd0, bolme_bitti_o}, 32'd1);

    islem_yap("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33, 0); bosta();
    islem_yap("REMU 100/7", REMU, 32'd100, 32'd7, 32'd2, 33, 0); bosta();
    islem_yap("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1); bosta();
    islem_yap("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0); bosta();
    islem_yap("DIV 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0); bosta();
    islem_yap("REM 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0); bosta();
    islem_yap("DIV 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0); bosta();
    islem_yap("REMU 5/0", REMU, 32'd5, 32'd0, 32'd5, 0, 0); bosta();
    islem_yap("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0); bosta();
    islem_yap("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0); bosta();
    islem_yap("DIVU ovf operands", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0); bosta();
    islem_yap("DIVU by 1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0); bosta();
    islem_yap("DIVU small", DIVU, 32'd3, 32'd10, 32'd0, 33, 0); bosta();

    for (int k = 0; k < 4; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom_range(1, 70000);
      if (k == 1) r_b = 32'hFFFF_FFF3;
      islem_yap("random", r_op, r_a, r_b, beklenen_sonuc(r_op, r_a, r_b), 33, 0); bosta();
    end
    islem_yap("REMU 3/10", REMU, 32'd3, 32'd10, 32'd3, 33, 0); bosta();

    // Reset in HESAPLA cycle 10 discards the operation
    @(posedge clk_i); #1;
    basla_i = 1'b1; islem_i = DIVU; bolunen_i = 32'd1000; bolen_i = 32'd3;
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1; basla_i = 1'b0;
    @(negedge clk_i);
    kontrol("busy before reset", {31'd0, bolme_bitti_o}, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    kontrol("after reset bolme_bitti_o", {31'd0, bolme_bitti_o}, 32'd1);
    kontrol("after reset sonuc_o", sonuc_o, 32'd0);
    temiz = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (sonuc_o !== 32'd0 || bolme_bitti_o !== 1'b1) temiz = 0;
    end
    kontrol("no result after reset", {31'd0, temiz}, 32'd1);
    $display("reset mid-HESAPLA: sonuc=%h bolme_bitti=%b", sonuc_o, bolme_bitti_o);

    // Back-to-back: second op accepted in the cycle right after BITTI
    islem_yap("b2b DIVU 20/4", DIVU, 32'd20, 32'd4, 32'd5, 33, 0);
    islem_yap("b2b DIVU 9/2", DIVU, 32'd9, 32'd2, 32'd4, 33, 0);
    bosta();
    repeat (3) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", dogrulama, hata);
    $finish;
  end

endmodule
